vmem_arbiter: RTL and testbench

- Shares the single 32-bit data-memory port between the scalar load/store unit and the vector memory access unit.
- Both requesters use req/gnt handshakes. The vector unit holds its request until granted; its per-element advance is gated by v_gnt.
- Once a vector burst starts, the arbiter locks the port to the vector unit. A starvation counter inserts single scalar slots into long bursts.
- Read responses are returned in order. A small owner-tag FIFO steers each response back to the requester that issued the read.

---
 rtl/vmem_pkg.sv | 11 +
 rtl/vmem_tag_fifo.sv | 39 +++
 rtl/vmem_arbiter.sv | 95 +++++++++
 tb/tb_vmem_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vmem_pkg.sv
// vmem_pkg: shared lock-state encodings, owner tags and counter width for the vector/scalar memory arbiter.
package vmem_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VLOCK  = 2'd1,
        VSTEAL = 2'd2
    } state_e;
    localparam logic TAG_S = 1'b0;
    localparam logic TAG_V = 1'b1;
    localparam int STARVE_W = 8;
endpackage

// File: rtl/vmem_tag_fifo.sv
// vmem_tag_fifo: 1-bit owner-tag FIFO recording which requester issued each outstanding read.
module vmem_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic din_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);
    localparam int AW = $clog2(DEPTH);
    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0] cnt_q;
    logic push_ok, pop_ok;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign head_o  = mem_q[rptr_q];
    // a push into a full FIFO is only legal when the head leaves in the same cycle
    assign push_ok = push_i & (~full_o | pop_i);
    assign pop_ok  = pop_i & ~empty_o;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= push_ok ? wptr_q + 1'b1 : wptr_q;
            rptr_q <= pop_ok ? rptr_q + 1'b1 : rptr_q;
            cnt_q  <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= din_i;
    end
endmodule

// File: rtl/vmem_arbiter.sv
// vmem_arbiter: shares one data-memory port between the scalar LSU and the vector memory unit,
// locking to vector bursts with starvation slots and steering in-order read responses by owner tag.
module vmem_arbiter
    import vmem_pkg::*;
#(
    parameter int OUTSTANDING  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_req,
    input  logic        s_we,
    input  logic [31:0] s_addr,
    input  logic [31:0] s_wdata,
    output logic        s_gnt,
    output logic        s_rvalid,
    output logic [31:0] s_rdata,
    input  logic        v_busy,
    input  logic        v_read_en,
    input  logic        v_write_en,
    input  logic [31:0] v_addr,
    input  logic [31:0] v_wdata,
    output logic        v_gnt,
    output logic        v_rvalid,
    output logic [31:0] v_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  owner,
    output logic        err
);
    state_e state_q;
    logic [STARVE_W-1:0] starve_q;
    logic err_q;
    logic v_req, sel_v, sel_s, req_sel, blk, req_ok, grant, s_g, v_g, push, pop;
    logic full, empty, head;
    assign v_req   = v_read_en | v_write_en;
    assign sel_v   = state_q == VLOCK || (state_q == IDLE && v_req);
    assign sel_s   = state_q == VSTEAL || (state_q == IDLE && !v_req);
    assign req_sel = sel_v ? v_req : sel_s & s_req;
    assign mem_we    = sel_v ? v_write_en : s_we;
    assign mem_addr  = sel_v ? v_addr : s_addr;
    assign mem_wdata = sel_v ? v_wdata : s_wdata;
    // a same-cycle response frees a slot, so a full FIFO only blocks reads without one
    assign blk    = !mem_we && full && !mem_rvalid;
    assign req_ok = req_sel & ~blk;
    assign grant  = mem_gnt & req_ok;
    assign s_g    = grant & sel_s;
    assign v_g    = grant & sel_v;
    assign push   = grant & ~mem_we;
    assign pop    = mem_rvalid & ~empty;
    assign mem_req  = req_ok & ~rst;
    assign s_gnt    = s_g & ~rst;
    assign v_gnt    = v_g & ~rst;
    assign s_rvalid = pop & (head == TAG_S) & ~rst;
    assign v_rvalid = pop & (head == TAG_V) & ~rst;
    assign s_rdata  = mem_rdata;
    assign v_rdata  = mem_rdata;
    assign owner    = state_q;
    assign err      = err_q;
    vmem_tag_fifo #(.DEPTH(OUTSTANDING)) u_tags (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (sel_v ? TAG_V : TAG_S),
        .pop_i   (pop),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q    <= err_q | (mem_rvalid & empty);
            starve_q <= (state_q == IDLE || s_g) ? '0 :
                        (state_q == VLOCK && s_req && starve_q != '1) ? starve_q + 1'b1 : starve_q;
            case (state_q)
                IDLE:    if (v_g) state_q <= VLOCK;
                VLOCK:   if (!v_busy && !v_req) state_q <= IDLE;
                         else if (starve_q == STARVE_W'(STARVE_LIMIT) && s_req) state_q <= VSTEAL;
                // a withdrawn scalar request hands the port back to a still-busy vector unit
                VSTEAL:  if (s_g) state_q <= VLOCK;
                         else if (!s_req) state_q <= v_busy ? VLOCK : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vmem_arbiter.sv
// tb_vmem_arbiter: directed scenarios with a response scoreboard checked by an independent monitor.
module tb_vmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_req = 0, s_we = 0, v_busy = 0, v_read_en = 0, v_write_en = 0, mem_gnt = 0, mem_rvalid = 0;
    logic [31:0] s_addr = 0, s_wdata = 0, v_addr = 0, v_wdata = 0, mem_rdata = 0;
    logic s_gnt, s_rvalid, v_gnt, v_rvalid, mem_req, mem_we, err;
    logic [31:0] s_rdata, v_rdata, mem_addr, mem_wdata;
    logic [1:0] owner;
    int n_cmp = 0, n_bad = 0;
    typedef struct {
        logic v;
        logic [31:0] d;
    } rsp_t;
    rsp_t q[$];

    vmem_arbiter #(.OUTSTANDING(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .v_busy(v_busy), .v_read_en(v_read_en), .v_write_en(v_write_en),
        .v_addr(v_addr), .v_wdata(v_wdata),
        .v_gnt(v_gnt), .v_rvalid(v_rvalid), .v_rdata(v_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .owner(owner), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input logic v, input logic [31:0] d);
        rsp_t e;
        e.v = v;
        e.d = d;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (s_rvalid || v_rvalid) begin
            if (s_rvalid && v_rvalid) begin
                n_cmp++; n_bad++;
                $display("FAIL rsp_both: s_rvalid and v_rvalid both 1, expected one");
            end else if (q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rsp_unexpected: rvalid s=%0b v=%0b with no expected response", s_rvalid, v_rvalid);
            end else begin
                rsp_t e;
                e = q.pop_front();
                chk("rsp_port", {31'b0, v_rvalid}, {31'b0, e.v});
                chk("rsp_data", v_rvalid ? v_rdata : s_rdata, e.d);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int gcnt, gk;
        logic [1:0] gown, oa;
        logic gvg;
        #1;
        chk("rst_owner", owner, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_req", mem_req, 0);
        step; step;
        rst = 0;
        // scalar-only read
        s_req = 1; s_we = 0; s_addr = 32'h100; mem_gnt = 1;
        @(negedge clk);
        chk("s1_s_gnt", s_gnt, 1);
        chk("s1_mem_req", mem_req, 1);
        chk("s1_mem_addr", mem_addr, 32'h100);
        chk("s1_v_gnt", v_gnt, 0);
        step;
        s_req = 0;
        step;
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; expect_rsp(0, 32'hDEADBEEF);
        @(negedge clk);
        chk("s1_v_rvalid", v_rvalid, 0);
        chk("s1_owner", owner, 0);
        step;
        mem_rvalid = 0;
        // tie in IDLE, then a long vector write burst starving a scalar write
        s_req = 1; s_we = 1; s_addr = 32'h200; v_write_en = 1; v_busy = 1; v_addr = 32'h300;
        @(negedge clk);
        chk("tie_v_gnt", v_gnt, 1);
        chk("tie_s_gnt", s_gnt, 0);
        chk("tie_mem_addr", mem_addr, 32'h300);
        step;
        chk("tie_owner", owner, 1);
        gcnt = 0; gk = 0; gown = 0; oa = 0; gvg = 1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (s_gnt) begin
                gcnt++; gk = k; gown = owner; gvg = v_gnt;
            end
            if (gk != 0 && k == gk + 1) oa = owner;
            step;
            if (gk != 0) s_req = 0;
        end
        chk("starve_gnt_count", gcnt, 1);
        chk("starve_gnt_cycle", gk, 10);
        chk("starve_owner_steal", gown, 2);
        chk("starve_v_gnt_steal", gvg, 0);
        chk("starve_owner_after", oa, 1);
        v_write_en = 0; v_busy = 0; s_we = 0;
        step;
        chk("burst_end_owner", owner, 0);
        // outstanding limit
        v_read_en = 1; v_busy = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ost_v_gnt", v_gnt, 1);
            step;
        end
        @(negedge clk);
        chk("ost_block_mem_req", mem_req, 0);
        chk("ost_block_v_gnt", v_gnt, 0);
        step;
        v_read_en = 0; v_busy = 0;
        step;
        chk("ost_idle_owner", owner, 0);
        s_req = 1; s_we = 1; s_addr = 32'h400;
        @(negedge clk);
        chk("ost_write_gnt", s_gnt, 1);
        step;
        s_we = 0; mem_rvalid = 1; mem_rdata = 32'hA0; expect_rsp(1, 32'hA0);
        @(negedge clk);
        chk("ost_swap_gnt", s_gnt, 1);
        step;
        mem_rvalid = 0;
        @(negedge clk);
        chk("ost_still_full", mem_req, 0);
        step;
        s_req = 0;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = 1; mem_rdata = 32'hB1 + k; expect_rsp(k != 3, 32'hB1 + k);
            step;
        end
        mem_rvalid = 0;
        // interleaved S,V,S reads
        s_req = 1; s_we = 0;
        @(negedge clk);
        chk("il_s1_gnt", s_gnt, 1);
        step;
        s_req = 0; v_read_en = 1; v_busy = 1;
        @(negedge clk);
        chk("il_v_gnt", v_gnt, 1);
        step;
        v_read_en = 0; v_busy = 0;
        step;
        s_req = 1;
        @(negedge clk);
        chk("il_s2_gnt", s_gnt, 1);
        step;
        s_req = 0;
        for (int k = 1; k <= 3; k++) begin
            mem_rvalid = 1; mem_rdata = k; expect_rsp(k == 2, k);
            step;
        end
        mem_rvalid = 0;
        // stray response
        mem_rvalid = 1; mem_rdata = 32'h55;
        @(negedge clk);
        chk("stray_s_rvalid", s_rvalid, 0);
        chk("stray_v_rvalid", v_rvalid, 0);
        step;
        mem_rvalid = 0;
        chk("stray_err", err, 1);
        step;
        chk("stray_err_sticky", err, 1);
        rst = 1;
        #1;
        chk("stray_err_clr", err, 0);
        step;
        rst = 0;
        // async reset during a vector burst with two reads outstanding
        v_read_en = 1; v_busy = 1;
        step; step;
        chk("ar_owner_pre", owner, 1);
        s_req = 1;
        #2;
        rst = 1; mem_rvalid = 1; mem_rdata = 32'h77;
        #1;
        chk("ar_owner", owner, 0);
        chk("ar_v_gnt", v_gnt, 0);
        chk("ar_s_gnt", s_gnt, 0);
        chk("ar_mem_req", mem_req, 0);
        chk("ar_rvalid", {s_rvalid, v_rvalid}, 0);
        step;
        s_req = 0; v_read_en = 0; v_busy = 0; mem_rvalid = 0;
        rst = 0;
        step;
        chk("ar_err", err, 0);
        s_req = 1; s_addr = 32'h500;
        @(negedge clk);
        chk("ar_new_gnt", s_gnt, 1);
        step;
        s_req = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE0001; expect_rsp(0, 32'hCAFE0001);
        step;
        mem_rvalid = 0;
        step;
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
